// File: rtl/acc_chain_pkg.sv
// Shared types and constants for the accumulator chain controller.
package acc_chain_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SEL = 1'b1
  } step_state_e;

  localparam int unsigned MAX_STEPS           = 16;
  localparam int unsigned DEFAULT_WDOG_CYCLES = 64;

endpackage : acc_chain_pkg

// File: rtl/acc_chain_step_fsm.sv
// One chain step: RUN while fed by its own multiplier, SEL while it takes
// the previous accumulator's output. sel_o is the registered state.
module acc_chain_step_fsm
  import acc_chain_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clken_i,
  input  logic is_1x1_i,
  input  logic force_run_i,
  input  logic go_i,
  input  logic done_i,
  output logic sel_o
);

  step_state_e state_q, state_d;

  // State register, asynchronously returned to RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a simultaneous start and finish while in RUN keeps RUN.
  always_comb begin
    state_d = state_q;
    if (clken_i) begin
      if (is_1x1_i || force_run_i) begin
        state_d = RUN;
      end else begin
        case (state_q)
          RUN:     if (go_i && !done_i) state_d = SEL;
          SEL:     if (done_i) state_d = RUN;
          default: state_d = RUN;
        endcase
      end
    end
  end

  assign sel_o = (state_q == SEL);

endmodule : acc_chain_step_fsm

// File: rtl/acc_chain_ctrl.sv
// Controller for a chain of multiplier/accumulator datapaths: per-step
// hand-off FSMs, freeze/enable generation, chain completion and error flags.
// Optional freeze watchdog compiled in with macro ACC_CHAIN_WDOG_EN.
module acc_chain_ctrl
  import acc_chain_pkg::*;
#(
  parameter int unsigned STEPS       = 3,
  parameter int unsigned WDOG_CYCLES = DEFAULT_WDOG_CYCLES
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             aclken,
  input  logic             is_1x1,
  input  logic [STEPS-1:0] mul_valid,
  input  logic [STEPS-1:0] mul_last,
  input  logic [STEPS-1:0] acc_valid,
  input  logic [STEPS-1:0] acc_last,
  output logic [STEPS-1:0] mux_sel,
  output logic             mul_clken,
  output logic [STEPS-1:0] acc_clken,
  output logic             chain_done,
  output logic             err_overlap
`ifdef ACC_CHAIN_WDOG_EN
  ,output logic            err_wdog
`endif
);

  logic [STEPS-1:0] step_sel;
  logic             freeze;
  logic             force_run;
  logic             multi_sel;
  logic             chain_done_q, chain_done_d;
  logic             err_overlap_q, err_overlap_d;
  logic             unused_mul0;

  // Step 0 never selects its predecessor; its multiplier handshake is unused.
  assign step_sel[0] = 1'b0;
  assign unused_mul0 = mul_valid[0] & mul_last[0];

  for (genvar g = 1; g < STEPS; g++) begin : g_step
    acc_chain_step_fsm u_fsm (
      .clk_i       (aclk),
      .rst_ni      (aresetn),
      .clken_i     (aclken),
      .is_1x1_i    (is_1x1),
      .force_run_i (force_run),
      .go_i        (mul_valid[g] & mul_last[g]),
      .done_i      (acc_valid[g-1] & acc_last[g-1]),
      .sel_o       (step_sel[g])
    );
  end

  assign freeze    = |step_sel;
  assign multi_sel = |(step_sel & (step_sel - STEPS'(1)));
  assign mux_sel   = step_sel;
  assign mul_clken = aclken & ~freeze;
  assign acc_clken = {STEPS{aclken}} & ({STEPS{~freeze}} | step_sel);

  // Completion pulse and sticky overlap flag, next-state terms.
  always_comb begin
    chain_done_d  = aclken & acc_valid[STEPS-1] & acc_last[STEPS-1] & acc_clken[STEPS-1];
    err_overlap_d = err_overlap_q;
    if (aclken && !is_1x1 && multi_sel) begin
      err_overlap_d = 1'b1;
    end
  end

  // Completion pulse and sticky overlap flag registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      chain_done_q  <= 1'b0;
      err_overlap_q <= 1'b0;
    end else begin
      chain_done_q  <= chain_done_d;
      err_overlap_q <= err_overlap_d;
    end
  end

  assign chain_done  = chain_done_q;
  assign err_overlap = err_overlap_q;

`ifdef ACC_CHAIN_WDOG_EN
  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        err_wdog_q, err_wdog_d;
  logic        wdog_hit;

  // The flag rises on the edge the counter reaches the limit; the forced
  // return to RUN follows one cycle later, when the counter holds the limit.
  assign wdog_hit  = (wdog_cnt_q == 16'(WDOG_CYCLES));
  assign force_run = wdog_hit;

  // Watchdog counter and sticky flag, next-state terms.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    err_wdog_d = err_wdog_q;
    if (aclken) begin
      if (!freeze || wdog_hit) begin
        wdog_cnt_d = '0;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 16'd1;
      end
      if (freeze && (wdog_cnt_q == 16'(WDOG_CYCLES - 1))) begin
        err_wdog_d = 1'b1;
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wdog_cnt_q <= '0;
      err_wdog_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      err_wdog_q <= err_wdog_d;
    end
  end

  assign err_wdog = err_wdog_q;
`else
  logic unused_wdog;

  assign force_run   = 1'b0;
  assign unused_wdog = (WDOG_CYCLES == 0);
`endif

endmodule : acc_chain_ctrl
